tau_gemm_engine: RTL and testbench

// - Temporal-unary (tau) GEMM engine: C[DIM_M][DIM_N] = sum over k of a_k (outer) b_k.
// - Input is a stream of rank-1 beats (vector a, vector b) with valid/ready; output is the accumulated matrix with valid/ready.
// - Each a[i] is applied as a unary pulse train: b[j] is added once per cycle while the cycle count is below a[i].
// - Successor of the fixed-size tau multiplier array. Adds: rectangular M x N, K-deep accumulation, saturation,

---
 rtl/tau_gemm_engine.sv | 148 ++++++++++++++
 tb/tb_tau_gemm_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tau_gemm_engine.sv
// Temporal-unary GEMM engine: accumulates rank-1 beats a (outer) b into an M x N matrix,
// applying each a[i] as a pulse train of b[j] additions with saturation and a stream handshake.
module tau_gemm_engine #(
    parameter int unsigned DIM_M    = 4,
    parameter int unsigned DIM_N    = 4,
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned ACC_BITS = 24
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [DIM_M-1:0][BITWIDTH-1:0]                in_a,
    input  logic [DIM_N-1:0][BITWIDTH-1:0]                in_b,
    input  logic                                          in_last,
    input  logic                                          early_exit,
    output logic [DIM_M-1:0][DIM_N-1:0][ACC_BITS-1:0]     out,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic                                          overflow,
    output logic                                          busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [DIM_M-1:0][BITWIDTH-1:0]            a_q, a_d;
    logic [DIM_N-1:0][BITWIDTH-1:0]            b_q, b_d;
    logic                                      last_q, last_d;
    logic [BITWIDTH-1:0]                       win_q, win_d;
    logic [BITWIDTH-1:0]                       cnt_q, cnt_d;
    logic [DIM_M-1:0][DIM_N-1:0][ACC_BITS-1:0] acc_q, acc_d;
    logic                                      ovf_q, ovf_d;
    logic                                      clear_q, clear_d;
    logic                                      shown_q, shown_d;

    logic                accept;
    logic                run_end;
    logic [BITWIDTH-1:0] run_last;
    logic [BITWIDTH-1:0] max_a;
    logic [ACC_BITS:0]   sum;

    assign accept   = in_valid && in_ready;
    // A zero window still occupies one RUN cycle.
    assign run_last = (win_q == '0) ? '0 : win_q - BITWIDTH'(1);
    assign run_end  = (cnt_q == run_last);

    always_comb begin
        max_a = '0;
        for (int unsigned i = 0; i < DIM_M; i++) begin
            if (in_a[i] > max_a) max_a = in_a[i];
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (run_end) state_d = last_q ? StDone : StIdle;
            StDone:  if (out_valid && out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic; the result is presented one cycle after the last accumulate lands.
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        out_valid = (state_q == StDone) && shown_q;
        overflow  = ovf_q;
        out       = acc_q;
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        clear_d = clear_q;
        sum     = '0;
        shown_d = (state_q == StDone) && (state_d == StDone);
        if (accept) begin
            a_d     = in_a;
            b_d     = in_b;
            last_d  = in_last;
            win_d   = early_exit ? max_a : '1;
            cnt_d   = '0;
            clear_d = 1'b0;
            if (clear_q) begin
                acc_d = '0;
                ovf_d = 1'b0;
            end
        end else if (state_q == StRun) begin
            cnt_d = cnt_q + BITWIDTH'(1);
            for (int unsigned i = 0; i < DIM_M; i++) begin
                for (int unsigned j = 0; j < DIM_N; j++) begin
                    if (cnt_q < a_q[i]) begin
                        sum = {1'b0, acc_q[i][j]} + {{(ACC_BITS + 1 - BITWIDTH){1'b0}}, b_q[j]};
                        if (sum[ACC_BITS]) begin
                            acc_d[i][j] = '1;
                            ovf_d       = 1'b1;
                        end else begin
                            acc_d[i][j] = sum[ACC_BITS-1:0];
                        end
                    end
                end
            end
        end else if (out_valid && out_ready) begin
            clear_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            win_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            clear_q <= 1'b1;
            shown_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            last_q  <= last_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            clear_q <= clear_d;
            shown_q <= shown_d;
        end
    end

endmodule

// File: tb/tb_tau_gemm_engine.sv
// Directed bench for tau_gemm_engine: a 24-bit accumulator instance for the main cases and a
// 16-bit instance for saturation, selected through a shared stimulus bus.
module tb_tau_gemm_engine;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_last, early_exit, out_ready, sel16;
    logic [3:0][7:0] in_a, in_b;

    logic                  in_ready0, out_valid0, overflow0, busy0;
    logic [3:0][3:0][23:0] out0;
    logic                  in_ready1, out_valid1, overflow1, busy1;
    logic [3:0][3:0][15:0] out1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_acc    = 0;
    int t_first  = 0;
    int t_out    = 0;

    logic rdy, ov;
    assign rdy = sel16 ? in_ready1 : in_ready0;
    assign ov  = sel16 ? out_valid1 : out_valid0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tau_gemm_engine #(.DIM_M(4), .DIM_N(4), .BITWIDTH(8), .ACC_BITS(24)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid & ~sel16),
        .in_ready   (in_ready0),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .early_exit (early_exit),
        .out        (out0),
        .out_valid  (out_valid0),
        .out_ready  (out_ready & ~sel16),
        .overflow   (overflow0),
        .busy       (busy0)
    );

    tau_gemm_engine #(.DIM_M(4), .DIM_N(4), .BITWIDTH(8), .ACC_BITS(16)) u_dut16 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid & sel16),
        .in_ready   (in_ready1),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .early_exit (early_exit),
        .out        (out1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready & sel16),
        .overflow   (overflow1),
        .busy       (busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0][7:0] v4(input int e0, input int e1, input int e2, input int e3);
        logic [3:0][7:0] r;
        r[0] = 8'(e0);
        r[1] = 8'(e1);
        r[2] = 8'(e2);
        r[3] = 8'(e3);
        return r;
    endfunction

    // Starts and ends at posedge+1; t_acc is the cycle index of the accepting edge.
    task automatic send(input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                        input logic last, input logic ee);
        int n = 0;
        in_a       = a;
        in_b       = b;
        in_last    = last;
        early_exit = ee;
        while (!rdy && n < 600) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", rdy, 1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        t_acc    = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!ov && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        t_out = cyc;
        chk("out_valid_wait", ov, 1);
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; early_exit = 1'b0;
        out_ready = 1'b0; sel16 = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_overflow", overflow0, 0);
        chk("rst_out_zero", out0 == '0, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single beat with early exit, W=3
        send(v4(3, 0, 1, 2), v4(5, 1, 0, 7), 1'b1, 1'b1);
        wait_out();
        chk("t1_latency", t_out - t_acc, 4);
        chk("t1_r0c0", out0[0][0], 15);
        chk("t1_r0c1", out0[0][1], 3);
        chk("t1_r0c2", out0[0][2], 0);
        chk("t1_r0c3", out0[0][3], 21);
        chk("t1_row1_zero", out0[1] == '0, 1);
        chk("t1_r2c3", out0[2][3], 7);
        chk("t1_r3c0", out0[3][0], 10);
        chk("t1_r3c3", out0[3][3], 14);
        chk("t1_overflow", overflow0, 0);
        chk("t1_busy_done", busy0, 1);
        handoff();
        chk("t1_idle_ready", in_ready0, 1);
        chk("t1_idle_valid", out_valid0, 0);

        // Same beat, full window
        send(v4(3, 0, 1, 2), v4(5, 1, 0, 7), 1'b1, 1'b0);
        wait_out();
        chk("t2_latency", t_out - t_acc, 256);
        chk("t2_r0c0", out0[0][0], 15);
        chk("t2_r3c3", out0[3][3], 14);
        handoff();

        // K=3, all operands 255
        send(v4(255, 255, 255, 255), v4(255, 255, 255, 255), 1'b0, 1'b1);
        t_first = t_acc;
        send(v4(255, 255, 255, 255), v4(255, 255, 255, 255), 1'b0, 1'b1);
        chk("t3_beat_spacing", t_acc - t_first, 256);
        send(v4(255, 255, 255, 255), v4(255, 255, 255, 255), 1'b1, 1'b1);
        wait_out();
        chk("t3_latency", t_out - t_first, 768);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) chk("t3_elem", out0[i][j], 195075);
        end
        chk("t3_overflow", overflow0, 0);

        // Backpressure in DONE with a pending beat of ones
        in_a = v4(1, 1, 1, 1); in_b = v4(1, 1, 1, 1); in_last = 1'b1; early_exit = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready0, 0);
            chk("bp_out_valid", out_valid0, 1);
            chk("bp_out_stable", out0[2][1], 195075);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_ready", in_ready0, 1);
        chk("bp_release_valid", out_valid0, 0);
        @(posedge clk); #1;
        t_acc    = cyc;
        in_valid = 1'b0;
        chk("t3b_busy", busy0, 1);
        wait_out();
        chk("t3b_latency", t_out - t_acc, 2);
        chk("t3b_r1c2", out0[1][2], 1);
        chk("t3b_r3c0", out0[3][0], 1);
        chk("t3b_overflow", overflow0, 0);
        handoff();

        // 16-bit accumulators: saturation and sticky overflow per job
        sel16 = 1'b1;
        send(v4(255, 255, 255, 255), v4(255, 255, 255, 255), 1'b1, 1'b1);
        wait_out();
        chk("s1_r0c0", out1[0][0], 65025);
        chk("s1_overflow", overflow1, 0);
        handoff();
        send(v4(255, 255, 255, 255), v4(255, 255, 255, 255), 1'b0, 1'b1);
        send(v4(255, 255, 255, 255), v4(255, 255, 255, 255), 1'b1, 1'b1);
        wait_out();
        chk("s2_r3c3_sat", out1[3][3], 65535);
        chk("s2_r1c2_sat", out1[1][2], 65535);
        chk("s2_overflow", overflow1, 1);
        handoff();
        send(v4(1, 1, 1, 1), v4(1, 1, 1, 1), 1'b1, 1'b1);
        wait_out();
        chk("s3_r2c2", out1[2][2], 1);
        chk("s3_overflow", overflow1, 0);
        handoff();
        sel16 = 1'b0;

        // Reset in the middle of a K=2 job
        send(v4(200, 200, 200, 200), v4(3, 3, 3, 3), 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("mr_busy_before", busy0, 1);
        reset = 1'b1;
        #1;
        chk("mr_out_zero", out0 == '0, 1);
        chk("mr_out_valid", out_valid0, 0);
        chk("mr_busy", busy0, 0);
        chk("mr_in_ready", in_ready0, 1);
        chk("mr_overflow", overflow0, 0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        send(v4(1, 1, 1, 1), v4(2, 2, 2, 2), 1'b1, 1'b1);
        wait_out();
        chk("mr_r0c0", out0[0][0], 2);
        chk("mr_r3c3", out0[3][3], 2);
        chk("mr_r1c2", out0[1][2], 2);
        chk("mr_overflow_after", overflow0, 0);
        handoff();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
